// File: rtl/jtopl_pkg.sv
// Shared constants and FSM encoding for the OPL timer control slice.
package jtopl_pkg;

  localparam logic [7:0] REG_TA   = 8'h02;
  localparam logic [7:0] REG_TB   = 8'h03;
  localparam logic [7:0] REG_TCTL = 8'h04;
  localparam logic [7:0] REG_CSM  = 8'h08;

  localparam int TCTL_RST = 7;
  localparam int TCTL_MA  = 6;
  localparam int TCTL_MB  = 5;
  localparam int TCTL_STB = 1;
  localparam int TCTL_STA = 0;
  localparam int CSM_EN   = 7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } busy_state_t;

endpackage

// File: rtl/jtopl_wr_busy.sv
// Write strobe edge detector plus the write-busy window sequencer.
module jtopl_wr_busy
  import jtopl_pkg::*;
#(
  parameter int ADDR_WAIT = 12,
  parameter int DATA_WAIT = 84
) (
  input  logic clk,
  input  logic rst,
  input  logic cen,
  input  logic wr_act,
  input  logic addr,
  output logic accept,
  output logic busy
);

  localparam int MAX_WAIT = (ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT;
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] ADDR_CNT = CNT_W'(ADDR_WAIT);
  localparam logic [CNT_W-1:0] DATA_CNT = CNT_W'(DATA_WAIT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             r_wr_l;
  busy_state_t      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_strobe;

  assign w_strobe = wr_act & ~r_wr_l;
  assign accept   = w_strobe & (r_state == ST_IDLE) & ~rst;
  assign busy     = (r_state == ST_BUSY);

  // Previous write level; tracked through reset so a write held across reset is not a new strobe
  always_ff @(posedge clk) begin
    r_wr_l <= wr_act;
  end

  // Busy window: load the wait on an accepted strobe, then count cen ticks down to the last one
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_strobe) begin
            r_state <= ST_BUSY;
            r_cnt   <= addr ? DATA_CNT : ADDR_CNT;
          end
        end
        ST_BUSY: begin
          if (cen) begin
            if (r_cnt == CNT_ONE) begin
              r_state <= ST_IDLE;
            end
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/jtopl_timer_ctrl.sv
// CPU-side control for the OPL timer pair: register decode, busy window,
// status byte and CSM key-on generation.
module jtopl_timer_ctrl
  import jtopl_pkg::*;
#(
  parameter int ADDR_WAIT = 12,
  parameter int DATA_WAIT = 84
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       cenop,
  input  logic       zero,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic       addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       busy,
  output logic [7:0] value_A,
  output logic [7:0] value_B,
  output logic       load_A,
  output logic       load_B,
  output logic       flagen_A,
  output logic       flagen_B,
  output logic       clr_flag_A,
  output logic       clr_flag_B,
  input  logic       flag_A,
  input  logic       flag_B,
  input  logic       overflow_A,
  input  logic       irq_n,
  output logic       csm_keyon
);

  logic       w_wr_act;
  logic       w_accept;
  logic [7:0] r_sel;
  logic [7:0] r_value_a;
  logic [7:0] r_value_b;
  logic       r_load_a;
  logic       r_load_b;
  logic       r_flagen_a;
  logic       r_flagen_b;
  logic       r_clr_a;
  logic       r_clr_b;
  logic       r_csm_en;
  logic       r_keyon;
  logic [7:0] r_dout;

  assign w_wr_act = ~cs_n & ~wr_n;

  jtopl_wr_busy #(
    .ADDR_WAIT(ADDR_WAIT),
    .DATA_WAIT(DATA_WAIT)
  ) u_wr_busy (
    .clk    (clk),
    .rst    (rst),
    .cen    (cen),
    .wr_act (w_wr_act),
    .addr   (addr),
    .accept (w_accept),
    .busy   (busy)
  );

  // Register file decode; a reset-flag write leaves load and mask untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel      <= 8'h00;
      r_value_a  <= 8'h00;
      r_value_b  <= 8'h00;
      r_load_a   <= 1'b0;
      r_load_b   <= 1'b0;
      r_flagen_a <= 1'b1;
      r_flagen_b <= 1'b1;
      r_clr_a    <= 1'b0;
      r_clr_b    <= 1'b0;
      r_csm_en   <= 1'b0;
    end else begin
      r_clr_a <= 1'b0;
      r_clr_b <= 1'b0;
      if (w_accept) begin
        if (!addr) begin
          r_sel <= din;
        end else begin
          case (r_sel)
            REG_TA: r_value_a <= din;
            REG_TB: r_value_b <= din;
            REG_TCTL: begin
              if (din[TCTL_RST]) begin
                r_clr_a <= 1'b1;
                r_clr_b <= 1'b1;
              end else begin
                r_flagen_a <= ~din[TCTL_MA];
                r_flagen_b <= ~din[TCTL_MB];
                r_load_b   <= din[TCTL_STB];
                r_load_a   <= din[TCTL_STA];
              end
            end
            REG_CSM: r_csm_en <= din[CSM_EN];
            default: ;
          endcase
        end
      end
    end
  end

  // CSM key-on spans one sample period; a fresh overflow at the boundary re-arms it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_keyon <= 1'b0;
    end else if (cenop && zero) begin
      r_keyon <= r_csm_en & r_load_a & overflow_A;
    end else if (!r_csm_en) begin
      r_keyon <= 1'b0;
    end
  end

  // Status byte
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout <= 8'h00;
    end else begin
      r_dout <= {~irq_n, flag_A, flag_B, 5'd0};
    end
  end

  assign dout       = r_dout;
  assign value_A    = r_value_a;
  assign value_B    = r_value_b;
  assign load_A     = r_load_a;
  assign load_B     = r_load_b;
  assign flagen_A   = r_flagen_a;
  assign flagen_B   = r_flagen_b;
  assign clr_flag_A = r_clr_a;
  assign clr_flag_B = r_clr_b;
  assign csm_keyon  = r_keyon;

endmodule

// File: tb/tb_jtopl_timer_ctrl.sv
// Scoreboard bench: a per-cycle reference model pushes expected outputs and busy-window
// lengths; an independent monitor pops and compares them against the DUT.
module tb_jtopl_timer_ctrl;

  localparam int AW = 12;
  localparam int DW = 84;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cen = 1'b0, cenop = 1'b0, zero = 1'b0;
  logic       cs_n = 1'b1, wr_n = 1'b1, addr = 1'b0;
  logic [7:0] din = 8'h00;
  logic       flag_A = 1'b0, flag_B = 1'b0, overflow_A = 1'b0, irq_n = 1'b1;
  logic [7:0] dout, value_A, value_B;
  logic       busy, load_A, load_B, flagen_A, flagen_B, clr_flag_A, clr_flag_B, csm_keyon;

  jtopl_timer_ctrl #(.ADDR_WAIT(AW), .DATA_WAIT(DW)) dut (
    .clk(clk), .rst(rst), .cen(cen), .cenop(cenop), .zero(zero),
    .cs_n(cs_n), .wr_n(wr_n), .addr(addr), .din(din), .dout(dout), .busy(busy),
    .value_A(value_A), .value_B(value_B), .load_A(load_A), .load_B(load_B),
    .flagen_A(flagen_A), .flagen_B(flagen_B), .clr_flag_A(clr_flag_A), .clr_flag_B(clr_flag_B),
    .flag_A(flag_A), .flag_B(flag_B), .overflow_A(overflow_A), .irq_n(irq_n),
    .csm_keyon(csm_keyon)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] va, vb, dout;
    logic       la, lb, fa, fb, ca, cb, busy, key;
  } snap_t;

  snap_t sq[$];
  int    wq[$];
  int    n_chk = 0, n_fail = 0;

  // reference model state
  logic [7:0] m_sel = 8'h00, m_va = 8'h00, m_vb = 8'h00;
  logic       m_la = 1'b0, m_lb = 1'b0, m_fa = 1'b1, m_fb = 1'b1, m_csm = 1'b0, m_key = 1'b0;
  logic       m_wr_prev = 1'b0;
  int         m_busy_left = 0, m_wait = 0;
  int         ovf_mode = 1;     // 0 never, 1 random, 2 forced with cenop&zero

  function automatic void chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  task automatic cycle(input logic w, input logic a, input logic [7:0] d, input logic r);
    logic  strobe, key_n, ca;
    snap_t s;
    @(negedge clk);
    rst = r; cs_n = ~w; wr_n = ~w; addr = a; din = d;
    cen    = ($urandom_range(0, 1) == 1);
    cenop  = ($urandom_range(0, 1) == 1);
    zero   = ($urandom_range(0, 3) == 0);
    flag_A = ($urandom_range(0, 1) == 1);
    flag_B = ($urandom_range(0, 1) == 1);
    irq_n  = ($urandom_range(0, 1) == 1);
    overflow_A = (ovf_mode == 1) ? ($urandom_range(0, 2) == 0) : (ovf_mode == 2);
    if (ovf_mode == 2) begin cenop = 1'b1; zero = 1'b1; end
    ca = 1'b0;
    if (r) begin
      if (m_busy_left > 0) wq[wq.size()-1] = m_wait - m_busy_left;
      m_sel = 8'h00; m_va = 8'h00; m_vb = 8'h00; m_la = 1'b0; m_lb = 1'b0;
      m_fa = 1'b1; m_fb = 1'b1; m_csm = 1'b0; m_key = 1'b0; m_busy_left = 0;
      m_wr_prev = w;
      s.dout = 8'h00;
    end else begin
      strobe = w & ~m_wr_prev;
      m_wr_prev = w;
      if (cenop && zero) key_n = m_csm & m_la & overflow_A;
      else if (!m_csm)   key_n = 1'b0;
      else               key_n = m_key;
      if (m_busy_left > 0) begin
        if (cen) m_busy_left--;
      end else if (strobe) begin
        m_wait = a ? DW : AW;
        m_busy_left = m_wait;
        wq.push_back(m_wait);
        if (!a) m_sel = d;
        else begin
          case (m_sel)
            8'h02: m_va = d;
            8'h03: m_vb = d;
            8'h04: begin
              if (d[7]) ca = 1'b1;
              else begin m_fa = ~d[6]; m_fb = ~d[5]; m_lb = d[1]; m_la = d[0]; end
            end
            8'h08: m_csm = d[7];
            default: ;
          endcase
        end
      end
      m_key = key_n;
      s.dout = {~irq_n, flag_A, flag_B, 5'd0};
    end
    s.va = m_va; s.vb = m_vb; s.la = m_la; s.lb = m_lb; s.fa = m_fa; s.fb = m_fb;
    s.ca = ca; s.cb = ca; s.busy = (m_busy_left > 0); s.key = m_key;
    sq.push_back(s);
  endtask

  task automatic wr(input logic a, input logic [7:0] d);
    int h;
    h = $urandom_range(1, 3);
    repeat (h) cycle(1'b1, a, d, 1'b0);
    cycle(1'b0, a, d, 1'b0);
  endtask

  task automatic idle_wait();
    int g;
    g = 0;
    while (m_busy_left > 0 && g < 5000) begin cycle(1'b0, 1'b0, 8'h00, 1'b0); g++; end
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic reg_wr(input logic [7:0] ra, input logic [7:0] d);
    wr(1'b0, ra); idle_wait();
    wr(1'b1, d);  idle_wait();
  endtask

  // monitor: per-cycle output compare and busy-window length in cen ticks
  initial begin
    snap_t s;
    logic  prev_busy;
    int    ticks, e;
    prev_busy = 1'b0; ticks = 0;
    forever begin
      @(posedge clk); #1;
      if (sq.size() > 0) begin
        s = sq.pop_front();
        chk("value_A", int'(value_A), int'(s.va));
        chk("value_B", int'(value_B), int'(s.vb));
        chk("load_A", int'(load_A), int'(s.la));
        chk("load_B", int'(load_B), int'(s.lb));
        chk("flagen_A", int'(flagen_A), int'(s.fa));
        chk("flagen_B", int'(flagen_B), int'(s.fb));
        chk("clr_flag_A", int'(clr_flag_A), int'(s.ca));
        chk("clr_flag_B", int'(clr_flag_B), int'(s.cb));
        chk("busy", int'(busy), int'(s.busy));
        chk("dout", int'(dout), int'(s.dout));
        chk("csm_keyon", int'(csm_keyon), int'(s.key));
      end
      if (prev_busy && cen && !rst) ticks++;
      if (busy && !prev_busy) ticks = 0;
      if (!busy && prev_busy) begin
        if (wq.size() > 0) begin
          e = wq.pop_front();
          chk("busy_ticks", ticks, e);
        end else begin
          chk("busy_window_unexpected", 1, 0);
        end
      end
      prev_busy = busy;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ra, d;
    int         sel;
    repeat (3) cycle(1'b0, 1'b0, 8'h00, 1'b1);
    repeat (3) cycle(1'b0, 1'b0, 8'h00, 1'b0);
    // timer A value and timer control
    reg_wr(8'h02, 8'hF0);
    reg_wr(8'h04, 8'h03);
    wr(1'b1, 8'h80); idle_wait();
    wr(1'b1, 8'h41); idle_wait();
    // second data write inside the busy window is dropped
    wr(1'b0, 8'h03); idle_wait();
    wr(1'b1, 8'h55);
    repeat (5) cycle(1'b0, 1'b0, 8'h00, 1'b0);
    wr(1'b1, 8'hAA); idle_wait();
    // CSM key-on from a forced overflow at a sample boundary
    ovf_mode = 0;
    reg_wr(8'h08, 8'h80);
    reg_wr(8'h04, 8'h01);
    repeat (10) cycle(1'b0, 1'b0, 8'h00, 1'b0);
    ovf_mode = 2;
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    ovf_mode = 0;
    repeat (40) cycle(1'b0, 1'b0, 8'h00, 1'b0);
    ovf_mode = 1;
    repeat (100) cycle(1'b0, 1'b0, 8'h00, 1'b0);
    // reset in the middle of a busy window, with a strobe in the reset cycle
    wr(1'b1, 8'h11);
    repeat (4) cycle(1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 1'b1, 8'h22, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    repeat (3) cycle(1'b0, 1'b0, 8'h00, 1'b0);
    // randomized register traffic, sometimes without waiting out busy
    for (int i = 0; i < 30; i++) begin
      sel = $urandom_range(0, 4);
      case (sel)
        0: ra = 8'h02;
        1: ra = 8'h03;
        2: ra = 8'h04;
        3: ra = 8'h08;
        default: ra = 8'($urandom_range(0, 255));
      endcase
      d = 8'($urandom_range(0, 255));
      wr(1'b0, ra);
      if ($urandom_range(0, 2) != 0) idle_wait();
      wr(1'b1, d);
      if ($urandom_range(0, 3) != 0) idle_wait();
      repeat ($urandom_range(0, 20)) cycle(1'b0, 1'b0, 8'h00, 1'b0);
    end
    reg_wr(8'h08, 8'h00);
    idle_wait();
    repeat (3) cycle(1'b0, 1'b0, 8'h00, 1'b0);
    @(posedge clk); #2;
    chk("pending_busy_windows", wq.size(), 0);
    chk("pending_cycle_checks", sq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/jtopl_timer_ctrl.md
# jtopl_timer_ctrl

CPU-facing controller for the OPL timer pair. It decodes YM3812-style address and data writes into timer registers 0x02, 0x03, 0x04 and 0x08. It drives the load, mask and flag-clear controls of the timer block, and sequences the chip's write-busy windows. It also builds the status byte and generates the CSM key-on pulse from timer A overflow. It sits between the CPU bus decode and the timer block, alongside the main register file.

## Interface
Parameters:
- ADDR_WAIT, 12: `cen` ticks busy after an address write.
- DATA_WAIT, 84: `cen` ticks busy after a data write.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- cen  in  1  master clock enable (busy counting)
- cenop  in  1  operator clock enable
- zero  in  1  sample-period boundary, qualified by `cenop`
- cs_n  in  1  chip select, active-low
- wr_n  in  1  write strobe, active-low
- addr  in  1  0 = address port, 1 = data port
- din  in  8  CPU write data
- dout  out  8  status byte {irq, flag_A, flag_B, 5'b0}
- busy  out  1  write-busy window active
- value_A, value_B  out  8  timer start values
- load_A, load_B  out  1  timer run enables (level)
- flagen_A, flagen_B  out  1  flag enables; inverse of mask bits
- clr_flag_A, clr_flag_B  out  1  one-cycle flag-clear pulses
- flag_A, flag_B  in  1  masked timer flags
- overflow_A  in  1  timer A overflow
- irq_n  in  1  timer interrupt, active-low
- csm_keyon  out  1  CSM key-on request to the envelope generator

## Operation
- **Write strobe detection**
  - `wr_act = ~cs_n & ~wr_n`, registered as `wr_l`.
  - A strobe is `wr_act & ~wr_l`, detected in cycle N.
  - A strobe with `busy=1` is dropped. No state changes and the busy counter is not restarted.
- **Address write** (`addr=0`): `sel <= din`; busy loads ADDR_WAIT.
- **Data write** (`addr=1`): busy loads DATA_WAIT, and register `sel` is updated:
  - 0x02: `value_A <= din`.
  - 0x03: `value_B <= din`.
  - 0x04 with `din[7]=1`: `clr_flag_A` and `clr_flag_B` pulse for one clk. All other bits of the write are ignored, so load and mask are unchanged.
  - 0x04 with `din[7]=0`: `flagen_A <= ~din[6]`, `flagen_B <= ~din[5]`, `load_B <= din[1]`, `load_A <= din[0]`.
  - 0x08: `csm_en <= din[7]`.
  - Any other address: no effect here; busy still applies.
- **Busy FSM**
  - States: IDLE and BUSY.
  - IDLE→BUSY on an accepted strobe; the counter is loaded with the wait value.
  - In BUSY the counter decrements on `cen`. BUSY→IDLE when the counter is 1 and `cen` is high.
  - `busy = (state==BUSY)`.
- **Status**: `dout <= {~irq_n, flag_A, flag_B, 5'd0}`, registered every clk.
- **CSM key-on**
  - Set when `cenop & zero & csm_en & load_A & overflow_A`.
  - Otherwise cleared at the next `cenop & zero`, so a pulse lasts exactly one sample period.
  - A retrigger at that boundary keeps it high.
  - Clearing `csm_en` clears `csm_keyon` on the next clk.

## Timing
- A register write detected in cycle N shows its outputs in cycle N+1. `busy` also rises in N+1.
- `clr_flag_*` is high for cycle N+1 only.
- The busy window is exactly WAIT `cen` ticks, counted from the first `cen` at or after N+1.
- `dout` lags its inputs by 1 clk.
- Reset values:
  - `value_A = value_B = 0`, `load_A = load_B = 0`.
  - `flagen_A = flagen_B = 1`, `clr_flag_* = 0`.
  - `sel = 0`, `csm_en = 0`, `csm_keyon = 0`, `busy = 0`, `dout = 0x00`.
- Reset mid-busy forces IDLE; a strobe in the same cycle as rst is ignored.
- A write held low across many cycles is one strobe.
- Flag clear and a timer overflow in the same cycle resolve downstream; clear wins in the timer.

## Structure
- Shared package `jtopl_pkg` holds:
  - register constants REG_TA=8'h02, REG_TB=8'h03, REG_TCTL=8'h04, REG_CSM=8'h08;
  - bit positions TCTL_RST=7, TCTL_MA=6, TCTL_MB=5, TCTL_STB=1, TCTL_STA=0;
  - the FSM state encoding.
- One sub-module, `jtopl_wr_busy`: the strobe detector, the busy FSM and the counter. Inputs are `cen`, the strobe, `addr` and the wait parameters; outputs are `accept` and `busy`.

## Test plan
- Reset, then read: `dout=0x00`, `flagen=11`, `load=00`, `busy=0`.
- Write addr 0x02, wait out busy, write data 0xF0 → `value_A=0xF0` the cycle after the strobe; busy lasts 84 `cen` ticks.
- Write 0x04←0x03 → `load_A=load_B=1`. Then write 0x04←0x80 → one-cycle `clr_flag_A` and `clr_flag_B` pulses, loads unchanged.
- Write 0x04←0x41 → `flagen_A=0`, `flagen_B=1`, `load_A=1`.
- Issue a second data write during busy → dropped; registers and busy count unchanged.
- Set 0x08←0x80 with `load_A=1`, then force `overflow_A` at a `zero` → `csm_keyon` high for exactly one sample period.
